txframer: RTL and testbench
===========================

# txframer

Parametrised successor to the fixed 11-bit transmit shifter. It owns a small transmit FIFO with a ready/valid write port and builds each serial frame itself from per-frame configuration: 5..DATA_W data bits, optional even/odd parity, and 1 or 2 stop bits. Frames are shifted out LSB-first on the baud strobe from `baudgen`, back-to-back while the FIFO holds data. It sits between the host register interface and the serial pin of the USRT transmitter.

## Interface
Parameters:
- `DATA_W`, default 9: maximum data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.

Ports:
- `i_Pclk`  in  1: system clock; all logic is on the rising edge.
- `i_Rst_n`  in  1: reset, asynchronous, active-low.
- `i_Bclk`  in  1: baud strobe, one `i_Pclk` cycle high per bit time, from `baudgen`.
- `i_Valid`  in  1: write request.
- `i_Data`  in  DATA_W: write data; only the low `i_Data_Bits` bits are transmitted.
- `o_Ready`  out  1: high when the FIFO is not full.
- `i_Data_Bits`  in  4: data bits per frame.
- `i_Parity`  in  2: 00 none, 01 even, 10 odd, 11 treated as none.
- `i_Stop2`  in  1: 1 selects two stop bits.
- `o_Tx_Serial`  out  1: serial line; idles high.
- `o_Busy`  out  1: high while a frame is in progress.
- `o_Done`  out  1: one-cycle pulse at the end of each frame.
- `o_Level`  out  $clog2(FIFO_DEPTH+1): FIFO occupancy.

## Operation
- **Write.** A push occurs on any cycle with `i_Valid && o_Ready`. `o_Ready` is `!full` for the current FIFO state. There is no bypass when the FIFO is full: a push on a full FIFO is refused, even in a cycle that also pops.
- **Config sampling.** `i_Data_Bits`, `i_Parity` and `i_Stop2` are sampled into frame registers at the start tick of each frame. Changing them mid-frame has no effect on that frame.
- **Data-bit clamping.** `i_Data_Bits` below 5 is treated as 5; above DATA_W is treated as DATA_W.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. Every transition happens only on a cycle with `i_Bclk` high.
  - IDLE: on a tick with the FIFO non-empty, pop the head into the shift register, latch config, go to START, and drive `o_Tx_Serial` low.
  - START -> DATA on the next tick. Output data bit 0 and reset the bit counter to 0.
  - DATA: on each tick, shift right and increment the counter. After the bit with index `nbits-1` has been held for one bit time, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: hold the parity bit for one bit time. Even parity gives an even count of ones over data+parity; odd parity gives an odd count. Parity covers only the `nbits` transmitted data bits.
  - STOP: line high for 1 or 2 bit times. On the tick that ends the last stop bit:
    - pulse `o_Done` for that cycle;
    - if the FIFO is non-empty, pop in the same cycle and go to START, so the next start bit begins with no idle gap;
    - otherwise go to IDLE.
- **Outputs.** `o_Tx_Serial` is registered and driven from the state and shift register. `o_Busy` = state != IDLE.
- **Push and pop together.** Both are allowed in one cycle; `o_Level` is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle.

## Timing
- **Reset values:** `o_Tx_Serial`=1, `o_Busy`=0, `o_Done`=0, `o_Ready`=1, `o_Level`=0, FSM in IDLE, FIFO empty.
- **Reset mid-frame:** the line returns high immediately (asynchronous) and all queued data is discarded.
- **Write to line latency:** the start bit begins on the first `i_Bclk` tick strictly after the push cycle.
- **Line change timing:** the line changes in the cycle after each qualifying tick, since the output is registered. Each bit lasts exactly one tick interval.
- **Frame length:** 1 + nbits + (parity?1:0) + (Stop2?2:1) bit times; range 7..13.
- **`o_Done` spacing:** exactly one frame length apart when the FIFO is kept non-empty.
- **`o_Level` and `o_Ready`** update in the cycle after a push or pop.

## Structure
- Shared include `usrt_defs.vh` holds:
  - parity encodings `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - FSM state localparams;
  - `MIN_DATA_BITS`=5.
- One sub-module, `sync_fifo` (params `WIDTH`, `DEPTH`), with push/pop, full/empty and level. The pointers carry one extra wrap bit to distinguish full from empty. The same FIFO is reused by the future receiver.
- The top level holds the FSM, frame registers, parity reduction and bit counter.

## Test plan
All cases use `baudgen` with baud value 87 and a 100 ns clock.
- **Single frame, 8 data bits, no parity, 1 stop bit.** Push 0x5A with `i_Data_Bits`=8, `i_Parity`=00, `i_Stop2`=0. Expect line 0,0,1,0,1,1,0,1,0,1 (10 bit times), then one `o_Done` pulse, then idle high.
- **Parity.** Push 0x07 with 7 data bits and even parity: parity bit 1. Repeat with odd parity: parity bit 0. Check the 2-stop-bit frame is 12 bit times.
- **Back-to-back.** Push 4 words, which fills the FIFO. Expect `o_Ready`=0 after the 4th push and the 5th push refused. Expect 4 contiguous frames with no idle bit between them, 4 `o_Done` pulses one frame apart, and `o_Level` stepping 4→0.
- **Clamping.** `i_Data_Bits`=2 sends 5 data bits; `i_Data_Bits`=15 sends 9 data bits.
- **Mid-frame config change.** Change config during a frame: the current frame is unaffected and the next frame uses the new config.
- **Reset mid-frame.** Assert `i_Rst_n`=0 during the DATA state with 2 words queued. Expect the line high, `o_Level`=0, and no `o_Done` pulse; after release the line stays idle.

Source files
------------

// File: rtl/txframer_pkg.sv
// Shared definitions for the USRT transmit framer: parity encodings, FSM
// state codes, frame configuration record and the data-bit clamp helper.
package txframer_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int MIN_DATA_BITS = 5;

    // Per-frame configuration, captured when a frame's start bit is launched
    typedef struct packed {
        logic [3:0] nbits;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } frame_cfg_t;

    // Requested data-bit count limited to MIN_DATA_BITS..max_bits
    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        logic [3:0] r;
        r = req;
        if (req < 4'(MIN_DATA_BITS)) begin
            r = 4'(MIN_DATA_BITS);
        end else if (req > max_bits) begin
            r = max_bits;
        end
        return r;
    endfunction

endpackage

// File: rtl/txframer_if.sv
// Ready/valid write port of the transmit FIFO.
interface txframer_if #(parameter int DATA_W = 9);

    logic              i_Valid;
    logic [DATA_W-1:0] i_Data;
    logic              o_Ready;

    modport master (output i_Valid, output i_Data, input o_Ready);
    modport slave  (input i_Valid, input i_Data, output o_Ready);

endinterface

// File: rtl/txframer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; shared by transmitter and receiver.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = LW'(wptr - rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Storage array; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointers, cleared on reset to discard queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/txframer.sv
// Transmit framer: FIFO-fed serialiser building start/data/parity/stop
// frames from per-frame configuration, advancing on the baud strobe.
module txframer
    import txframer_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_Pclk,
    input  logic                              i_Rst_n,
    input  logic                              i_Bclk,
    txframer_if.slave                         wr,
    input  logic [3:0]                        i_Data_Bits,
    input  logic [1:0]                        i_Parity,
    input  logic                              i_Stop2,
    output logic                              o_Tx_Serial,
    output logic                              o_Busy,
    output logic                              o_Done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Level
);

    localparam logic [3:0] MAX_BITS = 4'(DATA_W);

    logic              full;
    logic              empty;
    logic              pop;
    logic [DATA_W-1:0] head;

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bit_cnt;
    logic              stop_cnt;
    logic              par_bit;
    logic              last_stop;
    frame_cfg_t        cfg;
    frame_cfg_t        next_cfg;
    logic              next_par;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Pclk),
        .rst_n (i_Rst_n),
        .push  (wr.i_Valid),
        .pop   (pop),
        .din   (wr.i_Data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (o_Level)
    );

    assign wr.o_Ready = !full;
    assign o_Busy     = (state != ST_IDLE);
    assign last_stop  = (state == ST_STOP) && (!cfg.stop2 || stop_cnt);
    assign pop        = i_Bclk && !empty && ((state == ST_IDLE) || last_stop);

    // Configuration and parity the next frame would use if launched this tick
    always_comb begin
        logic x;
        next_cfg.nbits   = clamp_bits(i_Data_Bits, MAX_BITS);
        next_cfg.par_en  = (i_Parity == PAR_EVEN) || (i_Parity == PAR_ODD);
        next_cfg.par_odd = (i_Parity == PAR_ODD);
        next_cfg.stop2   = i_Stop2;
        x = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(next_cfg.nbits)) begin
                x = x ^ head[i];
            end
        end
        next_par = x ^ next_cfg.par_odd;
    end

    // Frame sequencer: launches frames from the FIFO and walks the bit fields
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            par_bit     <= 1'b0;
            cfg         <= '0;
            o_Tx_Serial <= 1'b1;
            o_Done      <= 1'b0;
        end else begin
            o_Done <= i_Bclk && last_stop;
            if (pop) begin
                shreg       <= head;
                cfg         <= next_cfg;
                par_bit     <= next_par;
                o_Tx_Serial <= 1'b0;
                state       <= ST_START;
            end else if (i_Bclk) begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_START: begin
                        o_Tx_Serial <= shreg[0];
                        bit_cnt     <= '0;
                        state       <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == cfg.nbits - 4'd1) begin
                            if (cfg.par_en) begin
                                o_Tx_Serial <= par_bit;
                                state       <= ST_PARITY;
                            end else begin
                                o_Tx_Serial <= 1'b1;
                                stop_cnt    <= 1'b0;
                                state       <= ST_STOP;
                            end
                        end else begin
                            shreg       <= shreg >> 1;
                            o_Tx_Serial <= shreg[1];
                            bit_cnt     <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        o_Tx_Serial <= 1'b1;
                        stop_cnt    <= 1'b0;
                        state       <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            o_Tx_Serial <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    default: begin
                        o_Tx_Serial <= 1'b1;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_txframer.sv
// Scoreboard bench for txframer: expected frames are queued as words are
// written, a line monitor reassembles frames on each baud tick, and each
// scenario task compares what came out against what it queued.
module tb_txframer;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int BAUD       = 87;
    localparam int LW         = $clog2(FIFO_DEPTH+1);

    logic          i_Pclk;
    logic          i_Rst_n;
    logic          i_Bclk;
    logic [3:0]    i_Data_Bits;
    logic [1:0]    i_Parity;
    logic          i_Stop2;
    logic          o_Tx_Serial;
    logic          o_Busy;
    logic          o_Done;
    logic [LW-1:0] o_Level;

    txframer_if #(.DATA_W(DATA_W)) wr ();

    txframer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_Pclk      (i_Pclk),
        .i_Rst_n     (i_Rst_n),
        .i_Bclk      (i_Bclk),
        .wr          (wr),
        .i_Data_Bits (i_Data_Bits),
        .i_Parity    (i_Parity),
        .i_Stop2     (i_Stop2),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Level     (o_Level)
    );

    typedef struct {
        logic [15:0] bits;
        int          len;
    } exp_t;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          len;
        int          gap;
        int          level;
        logic        doneSeen;
        longint      startCycle;
        longint      doneCycle;
    } obs_t;

    exp_t   expQ[$];
    obs_t   obsQ[$];
    int     compared;
    int     mismatched;
    longint cycle;
    longint lastDoneCycle;
    int     doneCount;
    bit     lineLowSeen;
    int     monState;
    int     monGap;
    obs_t   cur;

    initial begin
        i_Pclk = 1'b0;
        forever #50 i_Pclk = ~i_Pclk;
    end

    // Free-running baud strobe: one clock high every BAUD clocks
    initial begin
        int cnt;
        cnt    = 0;
        i_Bclk = 1'b0;
        forever begin
            @(posedge i_Pclk);
            #1;
            cnt    = (cnt == BAUD - 1) ? 0 : cnt + 1;
            i_Bclk = (cnt == BAUD - 1);
        end
    end

    // Line monitor: one sample per baud tick, frames framed by the start bit
    initial begin
        int idx;
        cycle         = 0;
        lastDoneCycle = 0;
        doneCount     = 0;
        lineLowSeen   = 1'b0;
        monState      = 0;
        monGap        = 0;
        forever begin
            @(negedge i_Pclk);
            cycle++;
            if (!i_Rst_n) begin
                monState = 0;
                monGap   = 0;
            end else begin
                if (o_Done === 1'b1) begin
                    doneCount++;
                    lastDoneCycle = cycle;
                end
                if (o_Tx_Serial !== 1'b1) begin
                    lineLowSeen = 1'b1;
                end
                if (monState == 2) begin
                    cur.doneSeen  = o_Done;
                    cur.doneCycle = lastDoneCycle;
                    obsQ.push_back(cur);
                    monState = 0;
                end else if (i_Bclk) begin
                    if (monState == 0) begin
                        if (o_Tx_Serial === 1'b0) begin
                            cur.bits       = '0;
                            cur.n          = 1;
                            cur.gap        = monGap;
                            cur.level      = int'(o_Level);
                            cur.startCycle = cycle;
                            idx            = obsQ.size();
                            cur.len        = (idx < expQ.size()) ? expQ[idx].len : 13;
                            monGap         = 0;
                            monState       = 1;
                        end else begin
                            monGap++;
                        end
                    end else begin
                        cur.bits[cur.n] = o_Tx_Serial;
                        cur.n++;
                        if (cur.n >= cur.len) begin
                            monState = 2;
                        end
                    end
                end
            end
        end
    end

    // Reference frame: start, clamped LSB-first data, optional parity, stops
    function automatic exp_t buildFrame(input logic [8:0] data, input logic [3:0] req,
                                        input logic [1:0] par, input logic stop2);
        exp_t e;
        int   n;
        int   ones;
        int   idx;
        n = int'(req);
        if (n < 5) n = 5;
        if (n > 9) n = 9;
        e.bits = '0;
        ones   = 0;
        idx    = 1;
        for (int i = 0; i < n; i++) begin
            e.bits[idx] = data[i];
            if (data[i]) ones++;
            idx++;
        end
        if (par == 2'b01) begin
            e.bits[idx] = (ones % 2 == 1);
            idx++;
        end else if (par == 2'b10) begin
            e.bits[idx] = (ones % 2 == 0);
            idx++;
        end
        for (int s = 0; s < (stop2 ? 2 : 1); s++) begin
            e.bits[idx] = 1'b1;
            idx++;
        end
        e.len = idx;
        return e;
    endfunction

    task automatic setCfg(input logic [3:0] b, input logic [1:0] p, input logic s2);
        i_Data_Bits = b;
        i_Parity    = p;
        i_Stop2     = s2;
    endtask

    task automatic pushRaw(input logic [8:0] d);
        @(posedge i_Pclk);
        #1;
        wr.i_Valid = 1'b1;
        wr.i_Data  = d;
        @(posedge i_Pclk);
        #1;
        wr.i_Valid = 1'b0;
    endtask

    task automatic syncTick();
        int b;
        b = BAUD + 5;
        @(negedge i_Pclk);
        while (!i_Bclk && b > 0) begin
            @(negedge i_Pclk);
            b--;
        end
    endtask

    task automatic waitFrames(input int n, input string name, output bit ok);
        int budget;
        budget = n * 14 * BAUD + 4 * BAUD;
        while (obsQ.size() < n && budget > 0) begin
            @(negedge i_Pclk);
            budget--;
        end
        ok = (obsQ.size() >= n);
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got %0d frames expected %0d", name, obsQ.size(), n);
        end
    endtask

    task automatic test_reset();
        i_Rst_n    = 1'b0;
        wr.i_Valid = 1'b0;
        wr.i_Data  = '0;
        setCfg(4'd8, 2'b00, 1'b0);
        #220;
        compared++; if (o_Tx_Serial !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx: got %b expected 1", o_Tx_Serial); end
        compared++; if (o_Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", o_Busy); end
        compared++; if (o_Done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", o_Done); end
        compared++; if (wr.o_Ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", wr.o_Ready); end
        compared++; if (o_Level !== '0) begin mismatched++; $display("[TB] FAIL reset_level: got %0d expected 0", o_Level); end
        repeat (3) @(posedge i_Pclk);
        #1;
        i_Rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        obs_t o;
        bit   ok;
        int   doneBefore;
        setCfg(4'd8, 2'b00, 1'b0);
        doneBefore = doneCount;
        syncTick();
        expQ.push_back(buildFrame(9'h05A, 4'd8, 2'b00, 1'b0));
        pushRaw(9'h05A);
        waitFrames(1, "single", ok);
        if (ok) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            compared++; if (o.bits !== e.bits) begin mismatched++; $display("[TB] FAIL single_bits: got %h expected %h", o.bits, e.bits); end
            compared++; if (o.bits !== 16'h02B4) begin mismatched++; $display("[TB] FAIL single_pattern: got %h expected 02b4", o.bits); end
            compared++; if (o.doneSeen !== 1'b1) begin mismatched++; $display("[TB] FAIL single_done: got %b expected 1", o.doneSeen); end
            compared++; if (o.doneCycle - o.startCycle != longint'(9 * BAUD + 1)) begin mismatched++; $display("[TB] FAIL single_length: got %0d expected %0d", o.doneCycle - o.startCycle, 9 * BAUD + 1); end
        end
        repeat (3 * BAUD) @(negedge i_Pclk);
        compared++; if (doneCount - doneBefore != 1) begin mismatched++; $display("[TB] FAIL single_done_count: got %0d expected 1", doneCount - doneBefore); end
        compared++; if (o_Tx_Serial !== 1'b1) begin mismatched++; $display("[TB] FAIL single_idle_line: got %b expected 1", o_Tx_Serial); end
        compared++; if (o_Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle_busy: got %b expected 0", o_Busy); end
    endtask

    task automatic test_parity();
        logic [1:0] parSel [3];
        logic [3:0] nb     [3];
        logic       st2    [3];
        logic       parExp [3];
        int         parIdx [3];
        exp_t       e;
        obs_t       o;
        bit         ok;
        parSel = '{2'b01, 2'b10, 2'b01};
        nb     = '{4'd7, 4'd7, 4'd8};
        st2    = '{1'b0, 1'b0, 1'b1};
        parExp = '{1'b1, 1'b0, 1'b1};
        parIdx = '{8, 8, 9};
        for (int k = 0; k < 3; k++) begin
            setCfg(nb[k], parSel[k], st2[k]);
            syncTick();
            expQ.push_back(buildFrame(9'h007, nb[k], parSel[k], st2[k]));
            pushRaw(9'h007);
            waitFrames(1, "parity", ok);
            if (ok) begin
                e = expQ.pop_front();
                o = obsQ.pop_front();
                compared++; if (o.bits !== e.bits) begin mismatched++; $display("[TB] FAIL parity%0d_bits: got %h expected %h", k, o.bits, e.bits); end
                compared++; if (o.bits[parIdx[k]] !== parExp[k]) begin mismatched++; $display("[TB] FAIL parity%0d_bit: got %b expected %b", k, o.bits[parIdx[k]], parExp[k]); end
                compared++; if (o.doneSeen !== 1'b1) begin mismatched++; $display("[TB] FAIL parity%0d_done: got %b expected 1", k, o.doneSeen); end
                if (k == 2) begin
                    compared++; if (o.doneCycle - o.startCycle != longint'(11 * BAUD + 1)) begin mismatched++; $display("[TB] FAIL parity_stop2_length: got %0d expected %0d", o.doneCycle - o.startCycle, 11 * BAUD + 1); end
                end
            end
            repeat (2 * BAUD) @(negedge i_Pclk);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] words [4];
        exp_t       e;
        obs_t       o;
        bit         ok;
        longint     prevDone;
        words = '{9'h011, 9'h02C, 9'h1C3, 9'h0FE};
        prevDone = 0;
        setCfg(4'd8, 2'b00, 1'b0);
        syncTick();
        for (int k = 0; k < 4; k++) begin
            expQ.push_back(buildFrame(words[k], 4'd8, 2'b00, 1'b0));
            pushRaw(words[k]);
        end
        @(negedge i_Pclk);
        compared++; if (wr.o_Ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_full: got %b expected 0", wr.o_Ready); end
        compared++; if (o_Level !== LW'(4)) begin mismatched++; $display("[TB] FAIL b2b_level_full: got %0d expected 4", o_Level); end
        pushRaw(9'h0AA);
        @(negedge i_Pclk);
        compared++; if (o_Level !== LW'(4)) begin mismatched++; $display("[TB] FAIL b2b_refused_push: got %0d expected 4", o_Level); end
        waitFrames(4, "b2b", ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                e = expQ.pop_front();
                o = obsQ.pop_front();
                compared++; if (o.bits !== e.bits) begin mismatched++; $display("[TB] FAIL b2b%0d_bits: got %h expected %h", k, o.bits, e.bits); end
                compared++; if (o.doneSeen !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b%0d_done: got %b expected 1", k, o.doneSeen); end
                compared++; if (o.level != 3 - k) begin mismatched++; $display("[TB] FAIL b2b%0d_level: got %0d expected %0d", k, o.level, 3 - k); end
                if (k > 0) begin
                    compared++; if (o.gap != 0) begin mismatched++; $display("[TB] FAIL b2b%0d_gap: got %0d expected 0", k, o.gap); end
                    compared++; if (o.doneCycle - prevDone != longint'(e.len * BAUD)) begin mismatched++; $display("[TB] FAIL b2b%0d_done_spacing: got %0d expected %0d", k, o.doneCycle - prevDone, e.len * BAUD); end
                end
                prevDone = o.doneCycle;
            end
        end
        repeat (14 * BAUD) @(negedge i_Pclk);
        compared++; if (obsQ.size() != 0) begin mismatched++; $display("[TB] FAIL b2b_extra_frame: got %0d expected 0", obsQ.size()); end
        compared++; if (o_Level !== '0) begin mismatched++; $display("[TB] FAIL b2b_level_empty: got %0d expected 0", o_Level); end
        obsQ.delete();
    endtask

    task automatic test_clamp();
        logic [3:0] req   [2];
        logic [1:0] par   [2];
        logic [8:0] words [2];
        exp_t       e;
        obs_t       o;
        bit         ok;
        req   = '{4'd2, 4'd15};
        par   = '{2'b00, 2'b11};
        words = '{9'h1F3, 9'h1A5};
        for (int k = 0; k < 2; k++) begin
            setCfg(req[k], par[k], 1'b0);
            syncTick();
            expQ.push_back(buildFrame(words[k], req[k], par[k], 1'b0));
            pushRaw(words[k]);
            waitFrames(1, "clamp", ok);
            if (ok) begin
                e = expQ.pop_front();
                o = obsQ.pop_front();
                compared++; if (o.bits !== e.bits) begin mismatched++; $display("[TB] FAIL clamp%0d_bits: got %h expected %h", k, o.bits, e.bits); end
                compared++; if (o.doneCycle - o.startCycle != longint'((e.len - 1) * BAUD + 1)) begin mismatched++; $display("[TB] FAIL clamp%0d_length: got %0d expected %0d", k, o.doneCycle - o.startCycle, (e.len - 1) * BAUD + 1); end
            end
            repeat (2 * BAUD) @(negedge i_Pclk);
        end
    endtask

    task automatic test_midcfg();
        exp_t e;
        obs_t o;
        bit   ok;
        setCfg(4'd8, 2'b00, 1'b0);
        syncTick();
        expQ.push_back(buildFrame(9'h03C, 4'd8, 2'b00, 1'b0));
        pushRaw(9'h03C);
        expQ.push_back(buildFrame(9'h0F1, 4'd6, 2'b10, 1'b1));
        pushRaw(9'h0F1);
        repeat (3 * BAUD) @(negedge i_Pclk);
        setCfg(4'd6, 2'b10, 1'b1);
        waitFrames(2, "midcfg", ok);
        if (ok) begin
            for (int k = 0; k < 2; k++) begin
                e = expQ.pop_front();
                o = obsQ.pop_front();
                compared++; if (o.bits !== e.bits) begin mismatched++; $display("[TB] FAIL midcfg%0d_bits: got %h expected %h", k, o.bits, e.bits); end
                compared++; if (o.doneSeen !== 1'b1) begin mismatched++; $display("[TB] FAIL midcfg%0d_done: got %b expected 1", k, o.doneSeen); end
            end
        end
        repeat (2 * BAUD) @(negedge i_Pclk);
    endtask

    task automatic test_reset_midframe();
        int doneBefore;
        setCfg(4'd8, 2'b00, 1'b0);
        syncTick();
        for (int k = 0; k < 3; k++) begin
            expQ.push_back(buildFrame(9'(8'h81 + k), 4'd8, 2'b00, 1'b0));
            pushRaw(9'(8'h81 + k));
        end
        repeat (4 * BAUD) @(negedge i_Pclk);
        compared++; if (o_Level !== LW'(2)) begin mismatched++; $display("[TB] FAIL rstmid_level_before: got %0d expected 2", o_Level); end
        doneBefore = doneCount;
        #10;
        i_Rst_n = 1'b0;
        #1;
        expQ.delete();
        obsQ.delete();
        compared++; if (o_Tx_Serial !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_line: got %b expected 1", o_Tx_Serial); end
        compared++; if (o_Level !== '0) begin mismatched++; $display("[TB] FAIL rstmid_level: got %0d expected 0", o_Level); end
        compared++; if (o_Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy: got %b expected 0", o_Busy); end
        repeat (3) @(posedge i_Pclk);
        #1;
        i_Rst_n     = 1'b1;
        lineLowSeen = 1'b0;
        repeat (20 * BAUD) @(negedge i_Pclk);
        compared++; if (doneCount != doneBefore) begin mismatched++; $display("[TB] FAIL rstmid_done: got %0d pulses expected 0", doneCount - doneBefore); end
        compared++; if (lineLowSeen !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_line_idle: got low=%b expected 0", lineLowSeen); end
        compared++; if (obsQ.size() != 0) begin mismatched++; $display("[TB] FAIL rstmid_frames: got %0d expected 0", obsQ.size()); end
        compared++; if (o_Level !== '0) begin mismatched++; $display("[TB] FAIL rstmid_level_after: got %0d expected 0", o_Level); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        $display("[TB] txframer bench start");
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_clamp();
        test_midcfg();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
